rsa_job_arbiter: RTL and testbench

//  Shares one rsa4k modular-exponentiation engine among NUM_REQ requesters. Arbitrates round-robin and muxes the

---
 rtl/rsa_job_arbiter_pkg.sv | 28 ++
 rtl/rsa_job_arbiter_rr_pick.sv | 29 ++
 rtl/rsa_job_arbiter.sv | 137 +++++++++++++
 tb/tb_rsa_job_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_job_arbiter_pkg.sv
// Shared definitions for the rsa4k job arbiter: arbiter state encodings, default sizes
// and a small one-hot to index helper.
package rsa_job_arbiter_pkg;

    localparam int RSA_WIDTH_DEFAULT   = 4096;
    localparam int ARB_TIMEOUT_DEFAULT = 2**24;
    localparam int WDOG_W              = 25;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_ISSUE  = 3'd1,
        ARB_SETTLE = 3'd2,
        ARB_RUN    = 3'd3,
        ARB_RESP   = 3'd4,
        ARB_ABORT  = 3'd5
    } arb_state_t;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] onehot_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rsa_job_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after ptr, wrapping.
module rsa_job_arbiter_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    logic [PTR_W:0] idx;

    // NOTE: every variable written here gets a default first, so no path leaves one holding its old value (no latch).
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (PTR_W+1)'(ptr) + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!any && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one rsa4k engine among NUM_REQ requesters: round-robin grant, operand mux, go pulse,
// done-edge detection, and a watchdog that aborts hung jobs by resetting the engine.
module rsa_job_arbiter
    import rsa_job_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int RSA_WIDTH   = RSA_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*RSA_WIDTH-1:0] req_message,
    input  logic [NUM_REQ*RSA_WIDTH-1:0] req_exponent,
    input  logic [NUM_REQ*RSA_WIDTH-1:0] req_modulus,
    output logic [NUM_REQ-1:0]           req_grant,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic                         rsp_timeout,
    output logic [RSA_WIDTH-1:0]         rsp_cypher,
    output logic                         eng_go,
    output logic                         eng_reset,
    output logic [RSA_WIDTH-1:0]         eng_message,
    output logic [RSA_WIDTH-1:0]         eng_exponent,
    output logic [RSA_WIDTH-1:0]         eng_modulus,
    input  logic [RSA_WIDTH-1:0]         eng_cypher,
    input  logic                         eng_done
);

    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    arb_state_t             state, state_next;
    logic [NUM_REQ-1:0]     grant_next, pick_grant;
    logic                   pick_any;
    logic [PTR_W-1:0]       rr_ptr, ptr_next, owner;
    logic [WDOG_W-1:0]      wdog, wdog_next;
    logic                   done_q;
    logic                   timeout_next;
    logic [RSA_WIDTH-1:0]   cypher_next;
    logic                   abort;

    rsa_job_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            req_grant   <= '0;
            rsp_timeout <= 1'b0;
            rsp_cypher  <= '0;
            rr_ptr      <= '0;
            wdog        <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            req_grant   <= grant_next;
            rsp_timeout <= timeout_next;
            rsp_cypher  <= cypher_next;
            rr_ptr      <= ptr_next;
            wdog        <= wdog_next;
            done_q      <= eng_done;
        end
    end

    assign owner     = PTR_W'(onehot_index(8'(req_grant)));
    assign eng_reset = reset | abort;

    always_comb begin
        state_next   = state;
        grant_next   = req_grant;
        timeout_next = rsp_timeout;
        cypher_next  = rsp_cypher;
        ptr_next     = rr_ptr;
        wdog_next    = wdog;
        eng_go       = 1'b0;
        abort        = 1'b0;
        rsp_valid    = '0;
        case (state)
            ARB_IDLE: begin
                grant_next = pick_any ? pick_grant : '0;
                if (pick_any) state_next = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                eng_go     = 1'b1;
                state_next = ARB_SETTLE;
            end
            ARB_SETTLE: begin
                wdog_next  = '0;
                state_next = ARB_RUN;
            end
            ARB_RUN: begin
                wdog_next = wdog + 1'b1;
                // A done edge on the expiry cycle still counts as a normal completion.
                if (eng_done && !done_q) begin
                    cypher_next = eng_cypher;
                    state_next  = ARB_RESP;
                end else if (wdog == WDOG_LAST) begin
                    wdog_next  = '0;
                    state_next = ARB_ABORT;
                end
            end
            ARB_ABORT: begin
                // wdog doubles as the two-cycle abort counter.
                abort        = 1'b1;
                timeout_next = 1'b1;
                if (wdog == '0) wdog_next = WDOG_W'(1);
                else            state_next = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_valid    = req_grant;
                ptr_next     = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                grant_next   = '0;
                timeout_next = 1'b0;
                state_next   = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // AND-OR operand mux over the one-hot grant.
    always_comb begin
        eng_message  = '0;
        eng_exponent = '0;
        eng_modulus  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eng_message  = eng_message  | (req_message [i*RSA_WIDTH +: RSA_WIDTH] & {RSA_WIDTH{req_grant[i]}});
            eng_exponent = eng_exponent | (req_exponent[i*RSA_WIDTH +: RSA_WIDTH] & {RSA_WIDTH{req_grant[i]}});
            eng_modulus  = eng_modulus  | (req_modulus [i*RSA_WIDTH +: RSA_WIDTH] & {RSA_WIDTH{req_grant[i]}});
        end
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Directed bench for rsa_job_arbiter: behavioural engine model plus a scoreboard of expected responses.
module tb_rsa_job_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int T = 128;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_message, req_exponent, req_modulus;
    logic [N-1:0]     req_grant, rsp_valid;
    logic             rsp_timeout;
    logic [W-1:0]     rsp_cypher;
    logic             eng_go, eng_reset;
    logic [W-1:0]     eng_message, eng_exponent, eng_modulus, eng_cypher;
    logic             eng_done;

    always #5 clk = ~clk;

    rsa_job_arbiter #(.NUM_REQ(N), .RSA_WIDTH(W), .TIMEOUT_CYC(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_message  (req_message),
        .req_exponent (req_exponent),
        .req_modulus  (req_modulus),
        .req_grant    (req_grant),
        .rsp_valid    (rsp_valid),
        .rsp_timeout  (rsp_timeout),
        .rsp_cypher   (rsp_cypher),
        .eng_go       (eng_go),
        .eng_reset    (eng_reset),
        .eng_message  (eng_message),
        .eng_exponent (eng_exponent),
        .eng_modulus  (eng_modulus),
        .eng_cypher   (eng_cypher),
        .eng_done     (eng_done)
    );

    typedef struct {
        int         idx;
        logic [W-1:0] cypher;
        logic       timed_out;
        int         lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] op_m[N], op_e[N], op_d[N];
    int           checks = 0, errors = 0, cyc = 0, go_cyc = -1, req_cyc = 0;
    int           abort_start = -1, abort_len = 0, abort_pulses = 0, overlap = 0, hold_left = 0;
    bit           prev_abort = 1'b0;

    // Engine model state: done rises e_delay cycles after go; stale done held through the settle cycle.
    bit           e_busy = 1'b0, e_hang = 1'b0, e_use_override = 1'b0;
    int           e_k = 0, e_delay = 10;
    logic [W-1:0] e_res = '0, e_override = '0;

    function automatic logic [W-1:0] eng_fn(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] d);
        return (m ^ {e[W-9:0], e[W-1:W-8]}) + d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: observe DUT outputs at the falling edge, score responses, then update the engine.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (eng_go && eng_reset) overlap++;
        if (eng_reset && !reset) begin
            if (!prev_abort) begin
                abort_pulses++;
                abort_start = cyc;
                abort_len   = 0;
            end
            abort_len++;
        end
        prev_abort = eng_reset && !reset;
        if (eng_go) begin
            go_cyc = cyc;
            if (sb.size() > 0) begin
                chk("grant_at_go", 64'(req_grant), 64'(1) << sb[0].idx);
                chk("eng_message", 64'(eng_message), 64'(op_m[sb[0].idx]));
                chk("eng_exponent", 64'(eng_exponent), 64'(op_e[sb[0].idx]));
                chk("eng_modulus", 64'(eng_modulus), 64'(op_d[sb[0].idx]));
            end
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e.timed_out));
                chk("rsp_cypher", 64'(rsp_cypher), 64'(e.cypher));
                chk("rsp_latency", 64'(cyc - go_cyc), 64'(e.lat));
                if (hold_left > 0) begin
                    hold_left--;
                    if (hold_left == 0) req_valid = '0;
                end else begin
                    req_valid[e.idx] = 1'b0;
                end
            end
        end
        if (eng_reset) begin
            e_busy   = 1'b0;
            e_k      = 0;
            eng_done = 1'b0;
        end else if (eng_go) begin
            e_busy = 1'b1;
            e_k    = 0;
            e_res  = e_use_override ? e_override : eng_fn(eng_message, eng_exponent, eng_modulus);
        end else if (e_busy) begin
            e_k++;
            if (!e_hang && e_k == e_delay) begin
                eng_done   = 1'b1;
                eng_cypher = e_res;
                e_busy     = 1'b0;
            end else if (e_k >= 2) begin
                eng_done = 1'b0;
                if (e_k == 2) eng_cypher = $urandom;
            end
        end
    endtask

    task automatic run_jobs(input int budget, input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_all_responses"}, 64'(sb.size()), 64'(0));
        sb.delete();
        repeat (3) tick();
    endtask

    initial begin
        logic [W-1:0] c1;
        reset      = 1'b1;
        req_valid  = '0;
        eng_done   = 1'b0;
        eng_cypher = '0;
        for (int i = 0; i < N; i++) begin
            op_m[i] = $urandom;
            op_e[i] = $urandom;
            op_d[i] = $urandom;
            req_message [i*W +: W] = op_m[i];
            req_exponent[i*W +: W] = op_e[i];
            req_modulus [i*W +: W] = op_d[i];
        end

        repeat (3) tick();
        chk("reset_req_grant", 64'(req_grant), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_timeout", 64'(rsp_timeout), 64'(0));
        chk("reset_rsp_cypher", 64'(rsp_cypher), 64'(0));
        chk("reset_eng_go", 64'(eng_go), 64'(0));
        chk("reset_eng_reset", 64'(eng_reset), 64'(1));
        reset = 1'b0;
        tick();

        // Single job on requester 0, done 100 cycles after go.
        e_delay        = 100;
        e_use_override = 1'b1;
        e_override     = 32'h1234;
        sb.push_back('{idx: 0, cypher: 32'h1234, timed_out: 1'b0, lat: 101});
        req_valid = 4'b0001;
        req_cyc   = cyc;
        run_jobs(300, "single");
        chk("go_latency", 64'(go_cyc - req_cyc), 64'(1));
        e_use_override = 1'b0;

        // Stale done level from the previous job must not complete this one early.
        e_delay = 10;
        c1 = eng_fn(op_m[1], op_e[1], op_d[1]);
        sb.push_back('{idx: 1, cypher: c1, timed_out: 1'b0, lat: 11});
        req_valid = 4'b0010;
        run_jobs(200, "stale_done");

        // Hung engine: abort two cycles after the watchdog expires, cypher left unchanged.
        e_hang = 1'b1;
        sb.push_back('{idx: 2, cypher: c1, timed_out: 1'b1, lat: T + 4});
        req_valid = 4'b0100;
        run_jobs(T + 50, "timeout");
        chk("abort_start", 64'(abort_start - go_cyc), 64'(T + 2));
        chk("abort_len", 64'(abort_len), 64'(2));
        chk("abort_pulses", 64'(abort_pulses), 64'(1));
        e_hang = 1'b0;

        // Done rises on the expiry cycle: normal completion, no abort.
        e_delay = T + 1;
        sb.push_back('{idx: 3, cypher: eng_fn(op_m[3], op_e[3], op_d[3]), timed_out: 1'b0, lat: T + 2});
        req_valid = 4'b1000;
        run_jobs(T + 50, "race");
        chk("race_no_abort", 64'(abort_pulses), 64'(1));

        // Fairness: all four held for eight jobs, pointer is back at 0.
        e_delay   = 20;
        hold_left = 8;
        for (int k = 0; k < 8; k++)
            sb.push_back('{idx: k % N, cypher: eng_fn(op_m[k % N], op_e[k % N], op_d[k % N]), timed_out: 1'b0, lat: 21});
        req_valid = 4'b1111;
        run_jobs(8 * 40, "fairness");

        // Move the pointer to 2, then reset in the middle of a job on requester 2.
        sb.push_back('{idx: 1, cypher: eng_fn(op_m[1], op_e[1], op_d[1]), timed_out: 1'b0, lat: 21});
        req_valid = 4'b0010;
        run_jobs(100, "pre_reset");
        req_valid = 4'b0100;
        repeat (6) tick();
        chk("midrun_grant", 64'(req_grant), 64'(4'b0100));
        reset = 1'b1;
        tick();
        chk("midrun_reset_grant", 64'(req_grant), 64'(0));
        chk("midrun_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrun_reset_rsp_timeout", 64'(rsp_timeout), 64'(0));
        chk("midrun_reset_rsp_cypher", 64'(rsp_cypher), 64'(0));
        chk("midrun_reset_eng_go", 64'(eng_go), 64'(0));
        chk("midrun_reset_eng_reset", 64'(eng_reset), 64'(1));
        reset     = 1'b0;
        req_valid = '0;
        repeat (40) tick();

        // After reset the pointer is 0 again, so requester 0 wins over 2.
        sb.push_back('{idx: 0, cypher: eng_fn(op_m[0], op_e[0], op_d[0]), timed_out: 1'b0, lat: 21});
        sb.push_back('{idx: 2, cypher: eng_fn(op_m[2], op_e[2], op_d[2]), timed_out: 1'b0, lat: 21});
        req_valid = 4'b0101;
        run_jobs(200, "post_reset");

        chk("go_reset_overlap", 64'(overlap), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
